// File: rtl/aes_ct_hex_writer.sv
// aes_ct_hex_writer: Avalon-MM staging/display registers that drive the exported to_hex word.
// Define CT_READBACK_EN to let the bus read staging words S0..S3 back.
module aes_ct_hex_writer #(
  parameter int LOG2_DWELL = 23
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic [31:0] to_hex,
  output logic [1:0]  word_idx,
  output logic        frame_done
);

  localparam logic [LOG2_DWELL-1:0] DWELL_MAX = {LOG2_DWELL{1'b1}};

  logic [31:0]           stage_r [4];
  logic [31:0]           disp_r  [4];
  logic                  rotate_r;
  logic                  valid_r;
  logic [1:0]            idx_r;
  logic [LOG2_DWELL-1:0] cnt_r;
  logic [31:0]           to_hex_r;
  logic [31:0]           readdata_r;
  logic                  frame_done_r;

  logic                  stage_we_s;
  logic                  ctrl_we_s;
  logic                  commit_s;
  logic                  run_s;
  logic                  expire_s;
  logic [31:0]           rd_mux_s;

  // Bus write decode and dwell-expiry detection
  always_comb begin
    stage_we_s = avs_write & ~avs_address[2];
    ctrl_we_s  = avs_write & (avs_address == 3'd4);
    commit_s   = ctrl_we_s & avs_writedata[0];
    run_s      = rotate_r & valid_r;
    expire_s   = run_s & (cnt_r == DWELL_MAX);
  end

  // Read mux over pre-write register values
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_address)
      3'd5: rd_mux_s = {28'd0, rotate_r, idx_r, valid_r};
`ifdef CT_READBACK_EN
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux_s = stage_r[avs_address[1:0]];
`endif
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Staging words: every bus write to 0..3 lands here
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 4; i++) stage_r[i] <= 32'd0;
    end else if (stage_we_s) begin
      stage_r[avs_address[1:0]] <= avs_writedata;
    end
  end

  // Display words: snapshot of the staging words taken on commit
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 4; i++) disp_r[i] <= 32'd0;
    end else if (commit_s) begin
      for (int i = 0; i < 4; i++) disp_r[i] <= stage_r[i];
    end
  end

  // ROTATE level and sticky VALID flag
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rotate_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (ctrl_we_s) rotate_r <= avs_writedata[1];
      if (commit_s)  valid_r  <= 1'b1;
    end
  end

  // Dwell counter and word index; a commit overrides a coincident expiry
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_r        <= '0;
      idx_r        <= 2'd0;
      frame_done_r <= 1'b0;
    end else if (commit_s) begin
      cnt_r        <= '0;
      idx_r        <= 2'd0;
      frame_done_r <= 1'b0;
    end else if (expire_s) begin
      cnt_r        <= '0;
      idx_r        <= idx_r + 2'd1;
      frame_done_r <= (idx_r == 2'd3);
    end else begin
      if (run_s) cnt_r <= cnt_r + 1'b1;
      frame_done_r <= 1'b0;
    end
  end

  // Registered display word and read data
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      to_hex_r   <= 32'd0;
      readdata_r <= 32'd0;
    end else begin
      to_hex_r <= valid_r ? disp_r[idx_r] : 32'd0;
      if (avs_read) readdata_r <= rd_mux_s;
    end
  end

  assign to_hex       = to_hex_r;
  assign word_idx     = idx_r;
  assign frame_done   = frame_done_r;
  assign avs_readdata = readdata_r;

endmodule

// File: tb/tb_aes_ct_hex_writer.sv
// Self-checking bench for aes_ct_hex_writer (LOG2_DWELL=3): directed table, corner sequences,
// and random bus traffic against a tick-count reference model.
module tb_aes_ct_hex_writer;

  localparam int L  = 3;
  localparam int DW = 1 << L;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic        wr = 1'b0;
  logic [31:0] wd = 32'd0;
  logic        rd = 1'b0;
  logic [31:0] avs_readdata;
  logic [31:0] to_hex;
  logic [1:0]  word_idx;
  logic        frame_done;

  aes_ct_hex_writer #(.LOG2_DWELL(L)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr), .avs_write(wr), .avs_writedata(wd), .avs_read(rd),
    .avs_readdata(avs_readdata), .to_hex(to_hex), .word_idx(word_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: position is the number of running cycles since the last commit
  logic [31:0] m_stage [4];
  logic [31:0] m_disp  [4];
  bit          m_rot, m_valid, m_fd;
  int          m_ticks;
  logic [31:0] m_hex, m_rd;

  logic [31:0] words [4];

  typedef struct {
    logic [2:0]  addr;
    bit          wr;
    bit          rd;
    logic [31:0] wd;
    logic [31:0] exp_hex;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_idx();
    return 2'((m_ticks / DW) % 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    if (a == 3'd5) return {28'd0, m_rot, m_idx(), m_valid};
`ifdef CT_READBACK_EN
    if (a < 3'd4) return m_stage[a[1:0]];
`endif
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_stage[i] = 32'd0;
      m_disp[i]  = 32'd0;
    end
    m_rot = 1'b0; m_valid = 1'b0; m_fd = 1'b0; m_ticks = 0;
    m_hex = 32'd0; m_rd = 32'd0;
  endtask

  // One clock: model consumes the driven inputs, DUT is compared, inputs return to idle
  task automatic step();
    logic [31:0] nh;
    bit commit, running;
    @(posedge clk);
    nh = m_valid ? m_disp[m_idx()] : 32'd0;
    if (rd) m_rd = m_read(addr);
    commit  = wr && (addr == 3'd4) && wd[0];
    running = m_rot && m_valid;
    if (commit) begin
      for (int i = 0; i < 4; i++) m_disp[i] = m_stage[i];
      m_ticks = 0; m_valid = 1'b1; m_fd = 1'b0;
    end else if (running) begin
      m_ticks++;
      m_fd = (m_ticks % (4 * DW)) == 0;
    end else begin
      m_fd = 1'b0;
    end
    if (wr && addr < 3'd4) m_stage[addr[1:0]] = wd;
    if (wr && addr == 3'd4) m_rot = wd[1];
    m_hex = nh;
    #1;
    chk("to_hex", to_hex, m_hex);
    chk("word_idx", {30'd0, word_idx}, {30'd0, m_idx()});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    chk("readdata", avs_readdata, m_rd);
    addr = 3'd0; wr = 1'b0; rd = 1'b0; wd = 32'd0;
  endtask

  task automatic wr_op(input logic [2:0] a, input logic [31:0] d);
    addr = a; wr = 1'b1; wd = d;
    step();
  endtask

  task automatic rd_op(input logic [2:0] a);
    addr = a; rd = 1'b1;
    step();
  endtask

  initial begin
    int fd_cnt;
    logic [31:0] exp_rb;
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    tbl[0] = '{3'd5, 1'b0, 1'b1, 32'd0,        32'd0,        32'd0};
    tbl[1] = '{3'd0, 1'b1, 1'b0, 32'h11111111, 32'd0,        32'd0};
    tbl[2] = '{3'd1, 1'b1, 1'b0, 32'h22222222, 32'd0,        32'd0};
    tbl[3] = '{3'd2, 1'b1, 1'b0, 32'h33333333, 32'd0,        32'd0};
    tbl[4] = '{3'd3, 1'b1, 1'b0, 32'h44444444, 32'd0,        32'd0};
    tbl[5] = '{3'd4, 1'b1, 1'b0, 32'h00000001, 32'd0,        32'd0};
    tbl[6] = '{3'd0, 1'b0, 1'b0, 32'd0,        32'h11111111, 32'd0};
    tbl[7] = '{3'd5, 1'b0, 1'b1, 32'd0,        32'h11111111, 32'd1};

    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_to_hex", to_hex, 32'd0);
    chk("reset_word_idx", {30'd0, word_idx}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);

    // Directed table: staging, commit with rotation off, STATUS readback
    for (int i = 0; i < 8; i++) begin
      addr = tbl[i].addr; wr = tbl[i].wr; rd = tbl[i].rd; wd = tbl[i].wd;
      step();
      chk("tbl_hex", to_hex, tbl[i].exp_hex);
      chk("tbl_rd", avs_readdata, tbl[i].exp_rd);
    end
    for (int i = 0; i < 50; i++) begin
      step();
      chk("hold_hex", to_hex, 32'h11111111);
    end

    // Rotation: 8 cycles per word, frame_done once per 32 cycles
    wr_op(3'd4, 32'd3);
    fd_cnt = 0;
    for (int j = 1; j <= 64; j++) begin
      step();
      chk("rot_idx", {30'd0, word_idx}, 32'((j / DW) % 4));
      chk("rot_hex", to_hex, words[((j - 1) / DW) % 4]);
      chk("rot_fd", {31'd0, frame_done}, {31'd0, (j % (4 * DW)) == 0});
      if (frame_done) fd_cnt++;
    end
    chk("rot_fd_count", 32'(fd_cnt), 32'd2);

    // Commit on the edge where counter=7 and word_idx=2
    wr_op(3'd4, 32'd3);
    for (int j = 1; j <= 23; j++) step();
    chk("pre_collide_idx", {30'd0, word_idx}, 32'd2);
    wr_op(3'd4, 32'd3);
    chk("collide_idx", {30'd0, word_idx}, 32'd0);
    chk("collide_fd", {31'd0, frame_done}, 32'd0);
    for (int j = 1; j <= 7; j++) begin
      step();
      chk("collide_hold", {30'd0, word_idx}, 32'd0);
    end
    step();
    chk("collide_adv", {30'd0, word_idx}, 32'd1);

    // Staging write during rotation stays hidden until the next commit
    wr_op(3'd1, 32'hDEADBEEF);
    for (int j = 0; j < 40; j++) begin
      step();
      chk("isolate", {31'd0, to_hex == 32'hDEADBEEF}, 32'd0);
    end
    rd_op(3'd1);
`ifdef CT_READBACK_EN
    exp_rb = 32'hDEADBEEF;
`else
    exp_rb = 32'd0;
`endif
    chk("readback_s1", avs_readdata, exp_rb);
    wr_op(3'd4, 32'd3);
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j > DW) chk("new_word1", to_hex, 32'hDEADBEEF);
    end

    // Random bus traffic against the model
    for (int n = 0; n < 3000; n++) begin
      addr = 3'($urandom_range(0, 7));
      wr   = ($urandom_range(0, 99) < 20);
      rd   = ($urandom_range(0, 2) == 0);
      wd   = $urandom;
      if (addr == 3'd4) begin
        wd[0] = ($urandom_range(0, 7) == 0);
        wd[1] = ($urandom_range(0, 4) != 0);
      end
      step();
    end

    // Asynchronous reset in the middle of a rotation
    wr_op(3'd4, 32'd3);
    repeat (13) step();
    rd_op(3'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_to_hex", to_hex, 32'd0);
    chk("arst_word_idx", {30'd0, word_idx}, 32'd0);
    chk("arst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("arst_readdata", avs_readdata, 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    rd_op(3'd5);
    chk("post_rst_status", avs_readdata, 32'd0);
    for (int j = 0; j < 40; j++) begin
      step();
      chk("post_rst_idle", {30'd0, word_idx}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
